// File: rtl/runner_if.sv
// Handshake bundle between the obstacle stream / controls and the runner engine,
// plus the player status it reports to the renderer and score display.
interface runner_if;
  logic               new_frame;
  logic [15:0]        obstacle;
  logic               obstacle_valid;
  logic               firstrow;
  logic               duck;
  logic               jump;
  logic               left;
  logic               right;
  logic               game_over;
  logic [1:0]         player_lane;
  logic [1:0]         lane_target;
  logic               lane_shifting;
  logic signed [15:0] player_height;
  logic [15:0]        player_score;
  logic [4:0]         player_speed;
  logic [1:0]         player_state;

  modport master (
    output new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
    input  game_over, player_lane, lane_target, lane_shifting, player_height,
           player_score, player_speed, player_state
  );

  modport slave (
    input  new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
    output game_over, player_lane, lane_target, lane_shifting, player_height,
           player_score, player_speed, player_state
  );
endinterface

// File: rtl/runner_core.sv
// Per-frame runner engine: jump/duck physics, speed ramp, multi-frame lane
// changes and obstacle collision against the accumulated frame contents.
module runner_core #(
  parameter int NUM_LANES         = 3,
  parameter int HALF_BLOCK_LENGTH = 64,
  parameter int GRAVITY           = 3,
  parameter int VERTICAL_JUMP     = 10,
  parameter int DUCK_LIMIT        = 15,
  parameter int GROUND            = -128,
  parameter int MARGIN_OF_ERROR   = 10,
  parameter int SPEED_INIT        = 4,
  parameter int SPEED_MAX         = 16,
  parameter int SPEED_STEP_BLOCKS = 32,
  parameter int LANE_SHIFT_FRAMES = 4
) (
  input  logic     clk,
  input  logic     rst,
  runner_if.slave  bus
);
  localparam int unsigned PW  = $clog2(HALF_BLOCK_LENGTH);
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned SW  = $clog2(SPEED_STEP_BLOCKS + 1);
  localparam int unsigned DW  = $clog2(DUCK_LIMIT + 1);
  localparam int unsigned CW  = $clog2(LANE_SHIFT_FRAMES + 1);

  localparam logic signed [15:0] GND     = 16'(GROUND);
  localparam logic signed [15:0] TRAIN_G = 16'(GROUND + HALF_BLOCK_LENGTH);
  localparam logic signed [15:0] LOW_LIM = 16'(GROUND + HALF_BLOCK_LENGTH / 2);
  localparam logic signed [15:0] MOE     = 16'(MARGIN_OF_ERROR);
  localparam logic signed [7:0]  VJ      = 8'(VERTICAL_JUMP);
  localparam logic signed [7:0]  GRAV    = 8'(GRAVITY);

  localparam logic [1:0]    LANE_INIT  = 2'(NUM_LANES / 2);
  localparam logic [1:0]    LANE_MAX   = 2'(NUM_LANES - 1);
  localparam logic [PW-1:0] PROG_MID   = PW'(HALF_BLOCK_LENGTH / 2);
  localparam logic [4:0]    SPD_INIT   = 5'(SPEED_INIT);
  localparam logic [4:0]    SPD_MAX    = 5'(SPEED_MAX);
  localparam logic [CW-1:0] SHIFT_INIT = CW'(LANE_SHIFT_FRAMES);
  localparam logic [DW-1:0] DUCK_MAX   = DW'(DUCK_LIMIT);
  localparam logic [SW-1:0] STEP_MAX   = SW'(SPEED_STEP_BLOCKS);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_AIR  = 2'd1;
  localparam logic [1:0] S_DUCK = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic [1:0]         state_q, state_n;
  logic signed [15:0] height_q, height_n;
  logic signed [7:0]  vel_q, vel_n;
  logic [15:0]        score_q, score_n;
  logic [4:0]         speed_q, speed_n;
  logic [PW-1:0]      prog_q, prog_n;
  logic [SW-1:0]      step_q, step_n;
  logic [DW-1:0]      dcnt_q, dcnt_n;
  logic [CW-1:0]      scnt_q, scnt_n;
  logic [1:0]         lane_q, lane_n, tgt_q, tgt_n;
  logic               shift_q, shift_n, go_q, go_n;
  logic               lo_q, lo_n, hi_q, hi_n, mid_q, mid_n;
  logic               train_q, train_n, abort_q, abort_n, ramp_q, ramp_n;
  logic signed [15:0] ramp_g_q, ramp_g_n;

  // Contribution of the obstacle on this cycle, merged with what the frame already holds
  logic [2:0]         obs_type;
  logic [1:0]         obs_lane;
  logic               accept, on_lane, on_tgt, c_ramp;
  logic               e_lo, e_hi, e_mid, e_train, e_abort, e_ramp;
  logic signed [15:0] half_prog, ramp_c, e_ramp_g, frame_g;

  assign obs_type  = bus.obstacle[15:13];
  assign obs_lane  = bus.obstacle[12:11];
  assign accept    = bus.obstacle_valid && bus.firstrow && (state_q != S_DEAD);
  assign on_lane   = accept && (obs_lane == lane_q);
  assign on_tgt    = accept && shift_q && (obs_lane == tgt_q);
  assign half_prog = $signed(16'(prog_q >> 1));
  assign ramp_c    = (bus.obstacle[10:0] >= 11'd64) ? (GND + half_prog) : (LOW_LIM + half_prog);
  assign c_ramp    = on_lane && (obs_type == 3'b101);
  assign e_lo      = lo_q    | (on_lane && (obs_type == 3'b001));
  assign e_hi      = hi_q    | (on_lane && (obs_type == 3'b010));
  assign e_mid     = mid_q   | (on_lane && (obs_type == 3'b011));
  assign e_train   = train_q | (on_lane && (obs_type == 3'b100));
  assign e_abort   = abort_q | (on_tgt && (obs_type == 3'b100) && (height_q < TRAIN_G));
  assign e_ramp    = ramp_q  | c_ramp;
  assign e_ramp_g  = (c_ramp && (ramp_c > ramp_g_q)) ? ramp_c : ramp_g_q;
  // A train roof always sits above the highest possible ramp point
  assign frame_g   = e_train ? TRAIN_G : (e_ramp ? e_ramp_g : GND);

  logic               at_mid, die;
  logic [16:0]        ssum;
  logic [PW:0]        psum;
  logic [SW-1:0]      step_inc;
  logic [5:0]         spd_dbl;
  logic signed [7:0]  nv;
  logic signed [15:0] h_nv;

  assign at_mid   = (prog_q == PROG_MID);
  assign die      = (at_mid && e_lo && (height_q <= LOW_LIM))
                 || (at_mid && e_hi && (state_q != S_DUCK))
                 || (at_mid && e_mid && (state_q != S_DUCK) && (height_q <= LOW_LIM))
                 || (e_train && (height_q <= TRAIN_G))
                 || (e_ramp && (height_q <= e_ramp_g - MOE));
  assign ssum     = {1'b0, score_q} + 17'(speed_q);
  assign psum     = {1'b0, prog_q} + PW1'(speed_q);
  assign step_inc = step_q + SW'(1);
  assign spd_dbl  = {speed_q, 1'b0};
  assign nv       = vel_q - GRAV;
  assign h_nv     = height_q + 16'(nv);

  // Next-state: accumulate obstacles every cycle, close the frame on the strobe
  always_comb begin
    state_n  = state_q;  height_n = height_q; vel_n   = vel_q;
    score_n  = score_q;  speed_n  = speed_q;  prog_n  = prog_q;
    step_n   = step_q;   dcnt_n   = dcnt_q;   scnt_n  = scnt_q;
    lane_n   = lane_q;   tgt_n    = tgt_q;    shift_n = shift_q;
    go_n     = go_q;
    lo_n     = e_lo;     hi_n     = e_hi;     mid_n   = e_mid;
    train_n  = e_train;  abort_n  = e_abort;  ramp_n  = e_ramp;
    ramp_g_n = e_ramp_g;

    if (bus.new_frame && (state_q != S_DEAD)) begin
      lo_n = 1'b0; hi_n = 1'b0; mid_n = 1'b0;
      train_n = 1'b0; abort_n = 1'b0; ramp_n = 1'b0;
      ramp_g_n = GND;

      if (die) begin
        state_n = S_DEAD;
        go_n    = 1'b1;
      end else begin
        score_n = ssum[16] ? 16'hFFFF : ssum[15:0];
        prog_n  = psum[PW-1:0];
        if (psum[PW]) begin
          if (step_inc == STEP_MAX) begin
            step_n  = '0;
            speed_n = (spd_dbl > 6'(SPD_MAX)) ? SPD_MAX : spd_dbl[4:0];
          end else begin
            step_n = step_inc;
          end
        end

        case (state_q)
          S_RUN: begin
            if (bus.duck) begin
              state_n = S_DUCK; dcnt_n = DW'(1); height_n = frame_g;
            end else if (bus.jump) begin
              state_n = S_AIR; vel_n = VJ; height_n = height_q + 16'(VJ);
            end else begin
              height_n = frame_g;
            end
          end
          S_AIR: begin
            if (bus.duck) begin
              vel_n = -VJ; height_n = height_q - 16'(VJ);
            end else if (h_nv >= frame_g) begin
              height_n = h_nv; vel_n = nv;
            end else if (h_nv >= frame_g - MOE) begin
              height_n = frame_g; vel_n = '0; state_n = S_RUN;
            end else begin
              state_n = S_DEAD; go_n = 1'b1;
            end
          end
          S_DUCK: begin
            if (bus.jump) begin
              state_n = S_AIR; vel_n = VJ; height_n = height_q + 16'(VJ); dcnt_n = '0;
            end else if (dcnt_q < DUCK_MAX) begin
              dcnt_n = dcnt_q + DW'(1); height_n = frame_g;
            end else if (bus.duck) begin
              dcnt_n = DW'(1); height_n = frame_g;
            end else begin
              dcnt_n = '0; height_n = frame_g; state_n = S_RUN;
            end
          end
          default: ;
        endcase

        if (!shift_q) begin
          if (bus.left && (lane_q != 2'd0)) begin
            tgt_n = lane_q - 2'd1; shift_n = 1'b1; scnt_n = SHIFT_INIT;
          end else if (bus.right && (lane_q < LANE_MAX)) begin
            tgt_n = lane_q + 2'd1; shift_n = 1'b1; scnt_n = SHIFT_INIT;
          end
        end else if (e_abort) begin
          tgt_n = lane_q; shift_n = 1'b0; scnt_n = '0;
        end else begin
          scnt_n = scnt_q - CW'(1);
          if (scnt_q == CW'(1)) begin
            lane_n = tgt_q; shift_n = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;   height_q <= GND;      vel_q   <= '0;
      score_q <= '0;      speed_q  <= SPD_INIT; prog_q  <= '0;
      step_q  <= '0;      dcnt_q   <= '0;       scnt_q  <= '0;
      lane_q  <= LANE_INIT; tgt_q  <= LANE_INIT; shift_q <= 1'b0;
      go_q    <= 1'b0;
      lo_q    <= 1'b0;    hi_q     <= 1'b0;     mid_q   <= 1'b0;
      train_q <= 1'b0;    abort_q  <= 1'b0;     ramp_q  <= 1'b0;
      ramp_g_q <= GND;
    end else begin
      state_q <= state_n; height_q <= height_n; vel_q   <= vel_n;
      score_q <= score_n; speed_q  <= speed_n;  prog_q  <= prog_n;
      step_q  <= step_n;  dcnt_q   <= dcnt_n;   scnt_q  <= scnt_n;
      lane_q  <= lane_n;  tgt_q    <= tgt_n;    shift_q <= shift_n;
      go_q    <= go_n;
      lo_q    <= lo_n;    hi_q     <= hi_n;     mid_q   <= mid_n;
      train_q <= train_n; abort_q  <= abort_n;  ramp_q  <= ramp_n;
      ramp_g_q <= ramp_g_n;
    end
  end

  assign bus.game_over     = go_q;
  assign bus.player_lane   = lane_q;
  assign bus.lane_target   = tgt_q;
  assign bus.lane_shifting = shift_q;
  assign bus.player_height = height_q;
  assign bus.player_score  = score_q;
  assign bus.player_speed  = speed_q;
  assign bus.player_state  = state_q;
endmodule

// File: tb/tb_runner_core.sv
// Bench for runner_core: directed scenarios with fixed expectations, then
// randomized frames checked against a frame-level behavioural player model.
module tb_runner_core;
  localparam int HBL   = 64;
  localparam int SSB   = 2;
  localparam int GRD   = -128;
  localparam int VJ    = 10;
  localparam int GRAV  = 3;
  localparam int MOE   = 10;
  localparam int DLIM  = 15;
  localparam int SINIT = 4;
  localparam int SMAX  = 16;
  localparam int NL    = 3;
  localparam int LSF   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  runner_if bus();

  runner_core #(
    .NUM_LANES(NL), .HALF_BLOCK_LENGTH(HBL), .GRAVITY(GRAV), .VERTICAL_JUMP(VJ),
    .DUCK_LIMIT(DLIM), .GROUND(GRD), .MARGIN_OF_ERROR(MOE), .SPEED_INIT(SINIT),
    .SPEED_MAX(SMAX), .SPEED_STEP_BLOCKS(SSB), .LANE_SHIFT_FRAMES(LSF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Player model: state 0 RUN, 1 AIR, 2 DUCK, 3 DEAD
  int m_state, m_h, m_v, m_score, m_speed, m_prog, m_step, m_dcnt;
  int m_lane, m_tgt, m_shift, m_scnt, m_go;
  logic [15:0] m_obs[$];

  int jump_h [8] = '{-118, -111, -107, -106, -108, -113, -121, -128};

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_h = GRD; m_v = 0; m_score = 0; m_speed = SINIT;
    m_prog = 0; m_step = 0; m_dcnt = 0; m_lane = NL / 2; m_tgt = NL / 2;
    m_shift = 0; m_scnt = 0; m_go = 0;
    m_obs.delete();
  endfunction

  function automatic void model_frame(input bit d, input bit j, input bit l, input bit r);
    bit lo, hi, mid, tr, ab, rp;
    int rg, fg, g, nv, np;
    lo = 0; hi = 0; mid = 0; tr = 0; ab = 0; rp = 0;
    rg = GRD; fg = GRD;
    if (m_state == 3) begin
      m_obs.delete();
      return;
    end
    foreach (m_obs[k]) begin
      int t, ln, pos;
      t = int'(m_obs[k][15:13]);
      ln = int'(m_obs[k][12:11]);
      pos = int'(m_obs[k][10:0]);
      if (ln == m_lane) begin
        if (t == 1) lo = 1;
        if (t == 2) hi = 1;
        if (t == 3) mid = 1;
        if (t == 4) begin
          tr = 1;
          if (GRD + HBL > fg) fg = GRD + HBL;
        end
        if (t == 5) begin
          rp = 1;
          g = ((pos >= 64) ? GRD : GRD + HBL / 2) + m_prog / 2;
          if (g > rg) rg = g;
          if (g > fg) fg = g;
        end
      end
      if (m_shift != 0 && ln == m_tgt && t == 4 && m_h < GRD + HBL) ab = 1;
    end
    m_obs.delete();
    if (m_prog != HBL / 2) begin
      lo = 0; hi = 0; mid = 0;
    end
    if ((lo && m_h <= GRD + HBL / 2) || (hi && m_state != 2) ||
        (mid && m_state != 2 && m_h <= GRD + HBL / 2) ||
        (tr && m_h <= GRD + HBL) || (rp && m_h <= rg - MOE)) begin
      m_state = 3; m_go = 1;
      return;
    end
    m_score = (m_score + m_speed > 65535) ? 65535 : m_score + m_speed;
    np = m_prog + m_speed;
    if (np >= HBL) begin
      np -= HBL;
      m_step++;
      if (m_step == SSB) begin
        m_step = 0;
        m_speed = (2 * m_speed > SMAX) ? SMAX : 2 * m_speed;
      end
    end
    m_prog = np;
    case (m_state)
      0: begin
        if (d) begin m_state = 2; m_dcnt = 1; m_h = fg; end
        else if (j) begin m_state = 1; m_v = VJ; m_h += VJ; end
        else m_h = fg;
      end
      1: begin
        if (d) begin m_v = -VJ; m_h += m_v; end
        else begin
          nv = m_v - GRAV;
          if (m_h + nv >= fg) begin m_h += nv; m_v = nv; end
          else if (m_h + nv >= fg - MOE) begin m_h = fg; m_v = 0; m_state = 0; end
          else begin m_state = 3; m_go = 1; end
        end
      end
      2: begin
        if (j) begin m_state = 1; m_v = VJ; m_h += VJ; m_dcnt = 0; end
        else if (m_dcnt < DLIM) begin m_dcnt++; m_h = fg; end
        else begin
          m_h = fg;
          if (d) m_dcnt = 1;
          else begin m_dcnt = 0; m_state = 0; end
        end
      end
      default: ;
    endcase
    if (m_shift == 0) begin
      if (l && m_lane > 0) begin m_tgt = m_lane - 1; m_shift = 1; m_scnt = LSF; end
      else if (r && m_lane < NL - 1) begin m_tgt = m_lane + 1; m_shift = 1; m_scnt = LSF; end
    end else if (ab) begin
      m_tgt = m_lane; m_shift = 0; m_scnt = 0;
    end else begin
      m_scnt--;
      if (m_scnt == 0) begin m_lane = m_tgt; m_shift = 0; end
    end
  endfunction

  task automatic clear_in();
    bus.new_frame = 1'b0; bus.obstacle = '0; bus.obstacle_valid = 1'b0;
    bus.firstrow = 1'b0; bus.duck = 1'b0; bus.jump = 1'b0;
    bus.left = 1'b0; bus.right = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic present(input logic [15:0] o, input bit ov, input bit fr);
    bus.obstacle = o; bus.obstacle_valid = ov; bus.firstrow = fr;
    if (ov && fr) m_obs.push_back(o);
    @(negedge clk);
    clear_in();
  endtask

  task automatic frame(input bit d, input bit j, input bit l, input bit r,
                       input bit ov, input bit fr, input logic [15:0] o);
    bus.duck = d; bus.jump = j; bus.left = l; bus.right = r;
    bus.obstacle = o; bus.obstacle_valid = ov; bus.firstrow = fr;
    bus.new_frame = 1'b1;
    if (ov && fr) m_obs.push_back(o);
    model_frame(d, j, l, r);
    @(negedge clk);
    clear_in();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".height"}, bus.player_height, -128);
    chk({tag, ".score"}, bus.player_score, 0);
    chk({tag, ".speed"}, bus.player_speed, SINIT);
    chk({tag, ".lane"}, bus.player_lane, 1);
    chk({tag, ".target"}, bus.lane_target, 1);
    chk({tag, ".shifting"}, bus.lane_shifting, 0);
    chk({tag, ".state"}, bus.player_state, 0);
    chk({tag, ".game_over"}, bus.game_over, 0);
  endtask

  task automatic check_model();
    chk("rnd.height", bus.player_height, m_h);
    chk("rnd.score", bus.player_score, m_score);
    chk("rnd.speed", bus.player_speed, m_speed);
    chk("rnd.state", bus.player_state, m_state);
    chk("rnd.lane", bus.player_lane, m_lane);
    chk("rnd.target", bus.lane_target, m_tgt);
    chk("rnd.shifting", bus.lane_shifting, m_shift);
    chk("rnd.game_over", bus.game_over, m_go);
  endtask

  function automatic logic [15:0] rand_obs();
    logic [15:0] o;
    o[15:13] = 3'($urandom_range(0, 7));
    o[12:11] = 2'($urandom_range(0, 3));
    o[10:0]  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 63)) : 11'($urandom_range(64, 2047));
    return o;
  endfunction

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle run through two speed doublings
    idle(32);
    chk("ramp.speed32", bus.player_speed, 8);
    chk("ramp.score32", bus.player_score, 128);
    idle(8);
    chk("idle40.score", bus.player_score, 192);
    chk("idle40.height", bus.player_height, -128);
    chk("idle40.lane", bus.player_lane, 1);
    chk("idle40.state", bus.player_state, 0);
    idle(8);
    chk("ramp.speed48", bus.player_speed, 16);
    idle(16);
    chk("ramp.speed64", bus.player_speed, 16);
    chk("ramp.score64", bus.player_score, 512);

    // Jump arc from the ground
    do_reset();
    frame(0, 1, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk("jump.height", bus.player_height, jump_h[i]);
      chk("jump.state", bus.player_state, (i == 7) ? 0 : 1);
    end
    chk("jump.game_over", bus.game_over, 0);

    // Low barrier at mid-block kills, then DEAD holds
    do_reset();
    idle(8);
    frame(0, 0, 0, 0, 1, 1, {3'b001, 2'd1, 11'd0});
    chk("lo.game_over", bus.game_over, 1);
    chk("lo.state", bus.player_state, 3);
    frame(0, 1, 0, 1, 0, 0, 16'h0000);
    chk("dead.score", bus.player_score, 32);
    chk("dead.height", bus.player_height, -128);
    chk("dead.lane", bus.player_lane, 1);

    // Barrier away from mid-block is not honoured
    do_reset();
    idle(7);
    frame(0, 0, 0, 0, 1, 1, {3'b001, 2'd1, 11'd0});
    chk("lo_off.game_over", bus.game_over, 0);
    chk("lo_off.score", bus.player_score, 32);

    // High barrier while ducking survives
    do_reset();
    idle(7);
    frame(1, 0, 0, 0, 0, 0, 16'h0000);
    chk("duck.state", bus.player_state, 2);
    frame(1, 0, 0, 0, 1, 1, {3'b010, 2'd1, 11'd100});
    chk("hi_duck.game_over", bus.game_over, 0);
    chk("hi_duck.state", bus.player_state, 2);

    // Lane change right commits on the fourth following strobe
    do_reset();
    frame(0, 0, 0, 1, 0, 0, 16'h0000);
    chk("shift.start", bus.lane_shifting, 1);
    chk("shift.target", bus.lane_target, 2);
    chk("shift.lane0", bus.player_lane, 1);
    idle(3);
    chk("shift.still", bus.lane_shifting, 1);
    chk("shift.lane3", bus.player_lane, 1);
    idle(1);
    chk("shift.done", bus.lane_shifting, 0);
    chk("shift.lane4", bus.player_lane, 2);

    // Train in the target lane aborts the change without death
    do_reset();
    frame(0, 0, 0, 1, 0, 0, 16'h0000);
    present({3'b100, 2'd2, 11'd200}, 1'b1, 1'b1);
    idle(1);
    chk("abort.target", bus.lane_target, 1);
    chk("abort.shifting", bus.lane_shifting, 0);
    chk("abort.game_over", bus.game_over, 0);
    chk("abort.lane", bus.player_lane, 1);

    // Asynchronous reset in the middle of a duck
    do_reset();
    frame(1, 0, 0, 1, 0, 0, 16'h0000);
    chk("mid_duck.state", bus.player_state, 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Long idle run saturates the score
    idle(4200);
    chk("sat.score", bus.player_score, 65535);
    chk("sat.speed", bus.player_speed, 16);

    // Randomized frames against the model
    do_reset();
    for (int f = 0; f < 400; f++) begin
      int nobs;
      nobs = $urandom_range(0, 2);
      for (int k = 0; k < nobs; k++)
        present(rand_obs(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      frame($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rand_obs());
      check_model();
      if (m_state == 3) begin
        frame(0, 1, 1, 0, 1, 1, rand_obs());
        check_model();
        do_reset();
      end else if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
